// File: rtl/md_ctrl_pkg.sv
// Shared types and defaults for the multdiv issue controller.
// Pure declarations; no logic, no latency, no backpressure.
package md_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } md_op_t;

    localparam int EXC_REG_DEF      = 30;
    localparam int MUL_EXC_CODE_DEF = 4;
    localparam int DIV_EXC_CODE_DEF = 5;

endpackage

// File: rtl/md_timeout_counter.sv
// 6-bit saturating BUSY-cycle counter; o_hit marks the LIMIT-th counted cycle.
// Latency: count updates one cycle after i_en; o_hit is combinational from the count.
// Backpressure: none; i_clr has priority over i_en.
module md_timeout_counter #(
    parameter int LIMIT = 40
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);
    logic [5:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != 6'h3f)) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // Count is LIMIT-1 during the LIMIT-th enabled cycle, so the FSM can leave on that edge.
    assign o_hit = i_en && (r_cnt == 6'(LIMIT - 1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/interlock stage in front of the multdiv unit; optional watchdog under MD_TIMEOUT_EN.
// Latency: accept at T, start pulse at T+1, writeback one cycle after md_resultRDY.
// Backpressure: stall holds the pipeline from acceptance until the DONE cycle.
module md_issue_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int REG_W          = 5,
    parameter int EXC_REG        = EXC_REG_DEF,
    parameter int MUL_EXC_CODE   = MUL_EXC_CODE_DEF,
    parameter int DIV_EXC_CODE   = DIV_EXC_CODE_DEF,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_mul,
    input  logic             i_ex_is_div,
    input  logic [WIDTH-1:0] i_ex_opA,
    input  logic [WIDTH-1:0] i_ex_opB,
    input  logic [REG_W-1:0] i_ex_rd,
    output logic [WIDTH-1:0] o_md_operandA,
    output logic [WIDTH-1:0] o_md_operandB,
    output logic             o_md_ctrl_MULT,
    output logic             o_md_ctrl_DIV,
    input  logic [WIDTH-1:0] i_md_result,
    input  logic             i_md_exception,
    input  logic             i_md_resultRDY,
    output logic             o_stall,
    output logic             o_wb_valid,
    output logic [REG_W-1:0] o_wb_rd,
    output logic [WIDTH-1:0] o_wb_data
);
    md_state_t        r_state;
    md_op_t           r_op;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [REG_W-1:0] r_rd;
    logic             r_ctrl_mult;
    logic             r_ctrl_div;
    logic             r_wb_valid;
    logic [REG_W-1:0] r_wb_rd;
    logic [WIDTH-1:0] r_wb_data;

    logic             w_is_md;
    logic             w_accept;
    logic             w_timeout;
    logic             w_finish;
    logic             w_exc;
    logic [WIDTH-1:0] w_exc_code;

    assign w_is_md  = i_ex_valid && (i_ex_is_mul || i_ex_is_div);
    assign w_accept = (r_state == ST_IDLE) && w_is_md;

`ifdef MD_TIMEOUT_EN
    md_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_accept),
        .i_en    (r_state == ST_BUSY),
        .o_hit   (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // A real RDY always wins over a coincident watchdog hit.
    assign w_finish   = i_md_resultRDY || w_timeout;
    assign w_exc      = i_md_resultRDY ? i_md_exception : 1'b1;
    assign w_exc_code = (r_op == OP_MUL) ? WIDTH'(MUL_EXC_CODE) : WIDTH'(DIV_EXC_CODE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_MUL;
            r_opA       <= '0;
            r_opB       <= '0;
            r_rd        <= '0;
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
        end else begin
            r_ctrl_mult <= 1'b0;
            r_ctrl_div  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_md) begin
                        r_opA       <= i_ex_opA;
                        r_opB       <= i_ex_opB;
                        r_rd        <= i_ex_rd;
                        r_op        <= i_ex_is_mul ? OP_MUL : OP_DIV;
                        r_ctrl_mult <= i_ex_is_mul;
                        r_ctrl_div  <= !i_ex_is_mul;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (w_finish) begin
                        r_wb_valid <= w_exc || (r_rd != '0);
                        r_wb_rd    <= w_exc ? REG_W'(EXC_REG) : r_rd;
                        r_wb_data  <= w_exc ? w_exc_code : i_md_result;
                        r_state    <= ST_DONE;
                    end
                end
                default: begin
                    r_opA   <= '0;
                    r_opB   <= '0;
                    r_rd    <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_stall        = w_accept || (r_state == ST_START) || (r_state == ST_BUSY);
    assign o_md_operandA  = r_opA;
    assign o_md_operandB  = r_opB;
    assign o_md_ctrl_MULT = r_ctrl_mult;
    assign o_md_ctrl_DIV  = r_ctrl_div;
    assign o_wb_valid     = r_wb_valid;
    assign o_wb_rd        = r_wb_rd;
    assign o_wb_data      = r_wb_data;

endmodule
